parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
Barrier-gate controller at the lot entrance. It produces the car-passed event that the space counter consumes. The block debounces the raw loop-detector and light-beam sensors and sequences the barrier motor through open, wait, pass and close. It emits exactly one single-cycle pass_pulse per car that fully crosses the beam. It refuses to open when the counter reports no free space.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a filtered sensor changes value (>=1)
MOTOR_CYCLES, 8, cycles the motor runs for a full open or full close stroke (>=1)
CAR_TIMEOUT, 32, cycles the gate stays open waiting for the beam before auto-closing (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
car_present  input  1  raw loop detector, asynchronous, bouncy; 1 = vehicle waiting at the gate
beam_broken  input  1  raw light beam under the barrier, asynchronous, bouncy; 1 = beam interrupted
space_ok  input  1  from the space counter; 1 = at least one free space (counter green lamp)
motor_up  output  1  drive barrier upward
motor_down  output  1  drive barrier downward
gate_open  output  1  barrier fully raised (WAIT_CAR or PASSING)
pass_pulse  output  1  one-cycle pulse per completed car passage; feeds the counter's entry input
deny  output  1  car waiting while the lot is full (IDLE, car_f=1, space_ok=0)
timeout  output  1  one-cycle pulse when the gate auto-closes without a passage

Behaviour:
- Reset (async assert): state=IDLE, timer=0, sync FFs=0, filtered signals=0, debounce counters=0. All outputs 0 while reset is high and on the first cycle after release. Reset mid-stroke aborts immediately. No pulse is emitted.
- Sensor filter, per input: 2-FF synchronizer, then a counter.
  - When the synced value differs from the filtered value for DEBOUNCE_CYCLES consecutive cycles, the filtered value flips.
  - Any matching sample clears the counter.
  - Latency from a clean edge to the filtered edge is 2+DEBOUNCE_CYCLES cycles.
  - Filtered outputs are car_f and beam_f.
- space_ok is already synchronous and is used unfiltered. It is sampled only in IDLE.
- Timer: loaded on state entry. It makes OPENING and CLOSING each last exactly MOTOR_CYCLES cycles, and WAIT_CAR at most CAR_TIMEOUT cycles.
- FSM:
  - IDLE: all motor outputs 0; deny = car_f & ~space_ok. car_f & space_ok -> OPENING.
  - OPENING: motor_up=1. After MOTOR_CYCLES cycles -> WAIT_CAR.
  - WAIT_CAR: gate_open=1. beam_f=1 -> PASSING; this takes priority over timeout on the same cycle. Timer expiry with beam_f=0 -> timeout=1 for one cycle, -> CLOSING.
  - PASSING: gate_open=1. Waits indefinitely for beam_f 1->0. On the cycle beam_f is first sampled 0: pass_pulse=1 for that one cycle, -> CLOSING.
  - CLOSING: motor_down=1. If beam_f=1 on any cycle: safety reversal -> OPENING with a fresh MOTOR_CYCLES load, no pulse. Otherwise after MOTOR_CYCLES cycles -> IDLE.
- After a reversal, the car is still counted once, via WAIT_CAR/PASSING.
- motor_up and motor_down are never both 1. Outputs are registered, or decoded from the registered state only.
- A car still present at the return to IDLE, with space_ok=1, reopens immediately (tailgating is handled as a new request).
- Car leaving the loop during OPENING or WAIT_CAR has no effect; the gate times out normally.

Test Plan:
- Normal passage (defaults): car_present=1 and space_ok=1 held -> OPENING entered 6 cycles after the raw edge; motor_up high exactly 8 cycles; gate_open=1. Then beam_broken 1 for 10 cycles, then 0 -> exactly one pass_pulse, 6 cycles after the beam's falling raw edge; then motor_down 8 cycles, then IDLE.
- Lot full: car_present=1, space_ok=0 -> deny=1 from the filtered edge onward; motor_up stays 0. Raise space_ok -> deny=0 next cycle, and OPENING is entered.
- Timeout: open the gate, never break the beam -> timeout pulses once exactly 32 cycles after WAIT_CAR entry; CLOSING follows; no pass_pulse.
- Bounce rejection: beam_broken glitches of 1-3 cycles during WAIT_CAR -> beam_f never rises; state is unchanged. Chatter of 20 toggles, then stable high -> exactly one PASSING entry and one pass_pulse after release.
- Safety reversal: break the beam at cycle 3 of CLOSING -> OPENING with motor_down=0 and motor_up=1 for a full 8 cycles. Complete the passage -> exactly one pass_pulse total.
- Async reset mid-PASSING: assert reset between clock edges -> all outputs 0 immediately; IDLE after release; no pass_pulse.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// parking_gate_ctrl
//
// Barrier-gate controller for the lot entrance. The raw loop detector and
// light beam are synchronized and debounced, and a five-state sequencer
// drives the barrier motor through open, wait, pass and close. One
// single-cycle pass_pulse is produced per car that fully crosses the beam.
// This pulse feeds the space counter. The gate refuses to open while the
// counter reports no free space.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing synchronized samples before a
//                    filtered sensor flips
//   MOTOR_CYCLES     cycles for a full open or close stroke
//   CAR_TIMEOUT      cycles the raised gate waits for the beam
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   car_present  raw loop detector (async, bouncy), 1 = car waiting
//   beam_broken  raw light beam (async, bouncy), 1 = beam interrupted
//   space_ok     synchronous, 1 = at least one free space
//   motor_up     drive barrier upward
//   motor_down   drive barrier downward
//   gate_open    barrier fully raised (WAIT_CAR or PASSING)
//   pass_pulse   one-cycle pulse per completed car passage
//   deny         car waiting while the lot is full
//   timeout      one-cycle pulse when the gate auto-closes without a passage
// ---------------------------------------------------------------------------
module parking_gate_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MOTOR_CYCLES    = 8,
   parameter int CAR_TIMEOUT     = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic car_present,
   input  logic beam_broken,
   input  logic space_ok,
   output logic motor_up,
   output logic motor_down,
   output logic gate_open,
   output logic pass_pulse,
   output logic deny,
   output logic timeout
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMAX = (MOTOR_CYCLES > CAR_TIMEOUT) ? MOTOR_CYCLES : CAR_TIMEOUT;
   localparam int TM_W = $clog2(TMAX + 1);

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TM_W-1:0] MOTOR_LOAD = TM_W'(MOTOR_CYCLES - 1);
   localparam logic [TM_W-1:0] WAIT_LOAD  = TM_W'(CAR_TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_OPENING = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_PASSING = 3'd3;
   localparam logic [2:0] S_CLOSING = 3'd4;

   // Bit 0 is the loop detector, bit 1 is the light beam.
   logic [1:0]      raw;
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      filt;
   logic [1:0]      filt_nxt;
   logic [DB_W-1:0] db_cnt [2];

   logic            car_next;
   logic            beam_next;

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic [TM_W-1:0] timer;
   logic [TM_W-1:0] timer_nxt;
   logic            timer_done;
   logic            pulse_nxt;
   logic            timeout_nxt;

   assign raw = {beam_broken, car_present};

   // Two-flop synchronizer followed by a run-length counter per sensor.
   // A sample that agrees with the filtered value clears the run. The
   // counter also wraps to zero on the sample that flips the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         filt  <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         filt  <= filt_nxt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i] || db_cnt[i] == DB_LAST)
               db_cnt[i] <= '0;
            else
               db_cnt[i] <= db_cnt[i] + 1'b1;
         end
      end
   end

   // The value each filtered sensor takes at the coming edge. The
   // sequencer reacts to this so that a state change lands on the same
   // edge as the filtered edge. All outputs stay registered.
   always_comb begin
      filt_nxt = filt;
      for (int i = 0; i < 2; i++) begin
         if (sync2[i] != filt[i] && db_cnt[i] == DB_LAST) filt_nxt[i] = sync2[i];
      end
   end

   assign car_next  = filt_nxt[0];
   assign beam_next = filt_nxt[1];

   // Sequencer. The timer is loaded on entry to each timed state and
   // counts down to zero. This gives exactly MOTOR_CYCLES cycles for
   // each stroke and at most CAR_TIMEOUT cycles of waiting. In CLOSING
   // the beam always wins, so a car under the barrier reverses the motor.
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      pulse_nxt   = 1'b0;
      timeout_nxt = 1'b0;
      timer_done  = (timer == '0);
      case (state)
         S_IDLE: begin
            if (car_next && space_ok) begin
               state_nxt = S_OPENING;
               timer_nxt = MOTOR_LOAD;
            end
         end
         S_OPENING: begin
            if (timer_done) begin
               state_nxt = S_WAIT;
               timer_nxt = WAIT_LOAD;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         S_WAIT: begin
            if (beam_next) begin
               state_nxt = S_PASSING;
            end else if (timer_done) begin
               timeout_nxt = 1'b1;
               state_nxt   = S_CLOSING;
               timer_nxt   = MOTOR_LOAD;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         S_PASSING: begin
            if (!beam_next) begin
               pulse_nxt = 1'b1;
               state_nxt = S_CLOSING;
               timer_nxt = MOTOR_LOAD;
            end
         end
         S_CLOSING: begin
            if (beam_next) begin
               state_nxt = S_OPENING;
               timer_nxt = MOTOR_LOAD;
            end else if (timer_done) begin
               state_nxt = S_IDLE;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, timer and outputs are all registered. The outputs are decoded
   // from the next state, so they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         timer      <= '0;
         motor_up   <= 1'b0;
         motor_down <= 1'b0;
         gate_open  <= 1'b0;
         pass_pulse <= 1'b0;
         deny       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         motor_up   <= (state_nxt == S_OPENING);
         motor_down <= (state_nxt == S_CLOSING);
         gate_open  <= (state_nxt == S_WAIT) || (state_nxt == S_PASSING);
         pass_pulse <= pulse_nxt;
         deny       <= (state_nxt == S_IDLE) && car_next && !space_ok;
         timeout    <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_parking_gate_ctrl
//
// Self-checking bench for parking_gate_ctrl with default parameters.
// Stimulus is driven on falling clock edges. Each scenario pushes the
// expected output changes, as {cycle, output vector}, into a queue. The
// monitor samples the outputs on every falling edge. Whenever the
// output vector changes, it pops one entry and compares both the cycle
// and the value. 'cyc' counts rising edges.
//
// Output vector order: {motor_up, motor_down, gate_open, pass_pulse,
//                       deny, timeout}
// ---------------------------------------------------------------------------
module tb_parking_gate_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic car_present;
   logic beam_broken;
   logic space_ok;
   logic motor_up;
   logic motor_down;
   logic gate_open;
   logic pass_pulse;
   logic deny;
   logic timeout;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   int n;
   int m;
   int r;
   int t;

   typedef struct {
      int         cyc;
      logic [5:0] vec;
   } ev_t;

   ev_t        exp_q [$];
   ev_t        mon_e;
   ev_t        left_e;
   logic [5:0] mon_cur;
   logic [5:0] prev_vec = '0;

   localparam logic [5:0] V_IDLE = 6'b000000;
   localparam logic [5:0] V_UP   = 6'b100000;
   localparam logic [5:0] V_OPEN = 6'b001000;
   localparam logic [5:0] V_PASS = 6'b010100;
   localparam logic [5:0] V_DOWN = 6'b010000;
   localparam logic [5:0] V_TO   = 6'b010001;
   localparam logic [5:0] V_DENY = 6'b000010;

   parking_gate_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .car_present (car_present),
      .beam_broken (beam_broken),
      .space_ok    (space_ok),
      .motor_up    (motor_up),
      .motor_down  (motor_down),
      .gate_open   (gate_open),
      .pass_pulse  (pass_pulse),
      .deny        (deny),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [5:0] out_vec();
      return {motor_up, motor_down, gate_open, pass_pulse, deny, timeout};
   endfunction

   task automatic expect_ev(input int c, input logic [5:0] v);
      ev_t e;
      e.cyc = c;
      e.vec = v;
      exp_q.push_back(e);
   endtask

   task automatic check_output(input string name, input logic [5:0] want);
      checks++;
      if (out_vec() !== want) begin
         failures++;
         $display("[TB] FAIL %s: outputs=%b required=%b", name, out_vec(), want);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Monitor: the motors must never both run. Any change of the output
   // vector must match the next queued expectation in value and cycle.
   always @(negedge clk) begin : monitor
      mon_cur = out_vec();
      checks++;
      if (motor_up && motor_down) begin
         failures++;
         $display("[TB] FAIL motor_exclusive at cyc %0d: up=%b down=%b required not both 1",
                  cyc, motor_up, motor_down);
      end
      if (mon_cur !== prev_vec) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_change at cyc %0d: outputs=%b required=%b (no change)",
                     cyc, mon_cur, prev_vec);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.vec !== mon_cur || mon_e.cyc != cyc) begin
               failures++;
               $display("[TB] FAIL event: got outputs=%b at cyc %0d, required outputs=%b at cyc %0d",
                        mon_cur, cyc, mon_e.vec, mon_e.cyc);
            end
         end
      end
      prev_vec = mon_cur;
   end

   initial begin
      reset       = 1'b1;
      car_present = 1'b0;
      beam_broken = 1'b0;
      space_ok    = 1'b0;
      @(negedge clk);
      check_output("reset_hold", V_IDLE);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_output("after_release", V_IDLE);

      // Normal passage: open 6 cycles after the raw edge, 8-cycle stroke,
      // then a 10-cycle beam break and a pulse 6 cycles after the release.
      $display("[TB] normal passage");
      n = cyc;
      car_present = 1'b1;
      space_ok    = 1'b1;
      expect_ev(n + 6,  V_UP);
      expect_ev(n + 14, V_OPEN);
      wait_until(n + 16);
      beam_broken = 1'b1;
      car_present = 1'b0;
      wait_until(n + 26);
      r = cyc;
      beam_broken = 1'b0;
      expect_ev(r + 6,  V_PASS);
      expect_ev(r + 7,  V_DOWN);
      expect_ev(r + 14, V_IDLE);
      wait_until(r + 20);

      // Lot full: deny from the filtered edge, then open one cycle after
      // space returns. The car leaves, so the gate times out after 32 cycles.
      $display("[TB] lot full and timeout");
      n = cyc;
      space_ok    = 1'b0;
      car_present = 1'b1;
      expect_ev(n + 6, V_DENY);
      wait_until(n + 10);
      m = cyc;
      space_ok = 1'b1;
      expect_ev(m + 1,  V_UP);
      expect_ev(m + 9,  V_OPEN);
      expect_ev(m + 41, V_TO);
      expect_ev(m + 42, V_DOWN);
      expect_ev(m + 49, V_IDLE);
      wait_until(m + 2);
      car_present = 1'b0;
      wait_until(m + 55);

      // Beam glitches of 1..3 cycles while waiting are rejected. The gate
      // still times out on schedule.
      $display("[TB] glitch rejection");
      n = cyc;
      car_present = 1'b1;
      expect_ev(n + 6,  V_UP);
      expect_ev(n + 14, V_OPEN);
      expect_ev(n + 46, V_TO);
      expect_ev(n + 47, V_DOWN);
      expect_ev(n + 54, V_IDLE);
      wait_until(n + 8);
      car_present = 1'b0;
      wait_until(n + 16);
      for (int len = 1; len <= 3; len++) begin
         beam_broken = 1'b1;
         repeat (len) @(negedge clk);
         beam_broken = 1'b0;
         repeat (3) @(negedge clk);
      end
      wait_until(n + 60);

      // Chatter: 20 one-cycle toggles, then stable high gives one passage.
      $display("[TB] chatter");
      n = cyc;
      car_present = 1'b1;
      expect_ev(n + 6,  V_UP);
      expect_ev(n + 14, V_OPEN);
      wait_until(n + 8);
      car_present = 1'b0;
      wait_until(n + 16);
      for (int i = 0; i < 20; i++) begin
         beam_broken = ~beam_broken;
         @(negedge clk);
      end
      beam_broken = 1'b1;
      wait_until(n + 44);
      r = cyc;
      beam_broken = 1'b0;
      expect_ev(r + 6,  V_PASS);
      expect_ev(r + 7,  V_DOWN);
      expect_ev(r + 14, V_IDLE);
      wait_until(r + 20);

      // Safety reversal: beam breaks during a timeout close. The gate
      // reopens for a full stroke, and the car is then counted once.
      $display("[TB] safety reversal");
      n = cyc;
      car_present = 1'b1;
      expect_ev(n + 6,  V_UP);
      expect_ev(n + 14, V_OPEN);
      expect_ev(n + 46, V_TO);
      expect_ev(n + 47, V_DOWN);
      wait_until(n + 8);
      car_present = 1'b0;
      wait_until(n + 46);
      t = cyc;
      beam_broken = 1'b1;
      expect_ev(t + 6,  V_UP);
      expect_ev(t + 14, V_OPEN);
      wait_until(t + 17);
      r = cyc;
      beam_broken = 1'b0;
      expect_ev(r + 6,  V_PASS);
      expect_ev(r + 7,  V_DOWN);
      expect_ev(r + 14, V_IDLE);
      wait_until(r + 20);

      // Async reset while PASSING: outputs clear at once, and no pulse follows.
      $display("[TB] async reset mid-passing");
      n = cyc;
      car_present = 1'b1;
      expect_ev(n + 6,  V_UP);
      expect_ev(n + 14, V_OPEN);
      wait_until(n + 8);
      car_present = 1'b0;
      wait_until(n + 16);
      beam_broken = 1'b1;
      wait_until(n + 25);
      #1 reset = 1'b1;
      #1 check_output("async_reset", V_IDLE);
      expect_ev(n + 26, V_IDLE);
      beam_broken = 1'b0;
      wait_until(n + 28);
      reset = 1'b0;
      @(negedge clk);
      check_output("release_first_cycle", V_IDLE);
      wait_until(n + 45);

      while (exp_q.size() > 0) begin
         left_e = exp_q.pop_front();
         checks++;
         failures++;
         $display("[TB] FAIL missing_event: never observed, required outputs=%b at cyc %0d",
                  left_e.vec, left_e.cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
